// File: rtl/mips_pkg.sv
// Shared MIPS fetch definitions: opcodes, fetch FSM states and queue entry layout.
package mips_pkg;

  localparam logic [5:0]  OP_RTYPE         = 6'h00;
  localparam logic [5:0]  OP_J             = 6'h02;
  localparam logic [5:0]  OP_BEQ           = 6'h04;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    WAIT_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} entries with push, pop and whole-queue flush.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(QDEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(QDEPTH);

  fetch_entry_t  mem_q [QDEPTH];
  fetch_entry_t  mem_d [QDEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  // Flush wins over a same-cycle push or pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: single outstanding memory request feeding a small queue,
// with beq/j redirect taken when the head instruction is consumed.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] immediate
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;

  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         q_full, q_empty;
  logic         accept, consume, redirect, push;
  logic [31:0]  head_plus4, redirect_target;

  assign imem_req    = !rst && (state_q == IDLE) && !q_full;
  assign imem_addr   = pc_q;
  assign accept      = imem_req && imem_ready;
  assign instr_valid = !rst && !q_empty;
  assign consume     = instr_valid && !stall;
  assign redirect    = consume && (jump || branch_taken);

  assign head_plus4      = head.pc + 32'd4;
  assign redirect_target = jump ? {head_plus4[31:28], jump_target, 2'b00}
                                : head_plus4 + (branch_offset << 2);

  // A response is kept only if nothing redirected since its request went out.
  assign push       = (state_q == WAIT) && imem_rvalid && !redirect;
  assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (accept) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end
    if (redirect) begin
      pc_d = redirect_target;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = redirect ? WAIT_DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = IDLE;
        end else if (redirect) begin
          state_d = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (imem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (consume),
    .flush     (redirect),
    .push_entry(push_entry),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // With the queue empty, pc_out shows the PC about to be fetched.
  assign instr  = instr_valid ? head.instr : 32'h0;
  assign pc_out = rst ? RESET_PC : (instr_valid ? head.pc : pc_q);

  assign opcode    = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign shamt     = instr[10:6];
  assign funct     = instr[5:0];
  assign immediate = instr[15:0];

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the word-aligned PC loaded on reset.
REQ-002 Parameter QDEPTH, default 2, SHALL set the instruction queue depth; only 2 is required.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 imem_req  out  1  fetch request valid.
REQ-006 imem_addr  out  32  fetch address, equals current PC.
REQ-007 imem_ready  in  1  memory accepts request this cycle.
REQ-008 imem_rvalid  in  1  read data valid.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 stall  in  1  downstream datapath cannot consume.
REQ-011 branch_taken  in  1  head instruction is beq and the ALU zero flag is set.
REQ-012 branch_offset  in  32  sign-extended immediate of head instruction.
REQ-013 jump  in  1  head instruction is j.
REQ-014 jump_target  in  26  j target field.
REQ-015 instr_valid  out  1  head instruction valid.
REQ-016 instr  out  32  head instruction word.
REQ-017 pc_out  out  32  PC of head instruction.
REQ-018 opcode/rs/rt/rd/shamt/funct/immediate  out  6/5/5/5/5/6/16  fields sliced from instr [31:26]/[25:21]/[20:16]/[15:11]/[10:6]/[5:0]/[15:0].

Function
REQ-019 Request accepted SHALL mean imem_req && imem_ready; PC SHALL advance to PC+4 (modulo 2^32) on acceptance only.
REQ-020 At most one request SHALL be outstanding; imem_req SHALL be 1 only in IDLE with queue occupancy < QDEPTH.
REQ-021 FSM states: IDLE (none outstanding), WAIT (outstanding, keep), WAIT_DROP (outstanding, discard).
REQ-022 IDLE->WAIT on acceptance without redirect; IDLE->WAIT_DROP on acceptance with redirect in the same cycle.
REQ-023 WAIT->IDLE on imem_rvalid, pushing {PC of request, imem_rdata}; WAIT->WAIT_DROP on redirect without imem_rvalid.
REQ-024 WAIT_DROP->IDLE on imem_rvalid, data discarded.
REQ-025 Minimum fetch latency SHALL be 1 cycle: rvalid in cycle after acceptance -> instr_valid the following cycle.
REQ-026 Consume SHALL mean instr_valid && !stall; consume pops queue head.
REQ-027 branch_taken, jump SHALL be sampled only on consume; otherwise ignored.
REQ-028 Redirect target: branch -> pc_out+4+(branch_offset<<2); jump -> {pc_out_plus4[31:28], jump_target, 2'b00}; jump SHALL have priority.
REQ-029 Redirect SHALL load PC with target, flush all queue entries, and drop any outstanding or same-cycle response.
REQ-030 Redirect and imem_rvalid in the same cycle: response SHALL be discarded, FSM -> IDLE.
REQ-031 Push and pop in the same cycle SHALL keep occupancy unchanged; full queue SHALL never be pushed (guaranteed by REQ-020).
REQ-032 stall SHALL hold instr, pc_out and all fields stable.

Reset
REQ-033 During rst: PC=RESET_PC, FSM=IDLE, queue empty, imem_req=0, instr_valid=0, instr=0, pc_out=RESET_PC, all fields 0.
REQ-034 rst mid-fetch SHALL abandon the outstanding request; memory is reset by the same rst.
REQ-035 First imem_req=1 SHALL occur in the first cycle after rst deasserts, imem_addr=RESET_PC.

Structure
REQ-036 Package mips_pkg SHALL hold OP_RTYPE 6'h00, OP_J 6'h02, OP_BEQ 6'h04, fetch FSM state enum, default RESET_PC.
REQ-037 Sub-module fetch_queue (QDEPTH-entry FIFO of {pc, instr}, push/pop/flush, full/empty) SHALL be instantiated once.

Verification
REQ-038 Reset, imem_ready=1, 1-cycle memory returning addr-based words -> fetches 0x0,0x4,0x8 in order, instr_valid from cycle 3.
REQ-039 stall=1 for 5 cycles with queue filling -> imem_req=0 at occupancy 2, head stable, no loss after release.
REQ-040 beq at PC 0x10, offset 32'hFFFF_FFFC, branch_taken=1 -> next imem_addr=0x04, queued/in-flight 0x14,0x18 dropped.
REQ-041 j at PC 0x4000_0020, jump_target 26'h000_0100 -> next fetch 0x4000_0400; jump+branch_taken together -> jump wins.
REQ-042 Redirect coinciding with imem_rvalid, then with acceptance -> both responses discarded, first valid instr from target.
REQ-043 rst asserted while WAIT with 3-cycle memory latency -> outputs at reset values, refetch from RESET_PC.
